// File: rtl/ctrl_pkg.sv
// Shared types and field layout for the microprogram sequencer.
// The sequencing field sits in the low bits of the ROM control word.
package ctrl_pkg;

    localparam int CW_WIDTH_DEF = 40;
    localparam int SEQ_FIELD_W  = 9;
    localparam int STACK_MAX    = 4;
    localparam logic [3:0] RESET_ADDR_DEF = 4'b0000;

    typedef enum logic [2:0] {
        OP_NEXT = 3'd0,
        OP_JUMP = 3'd1,
        OP_BRT  = 3'd2,
        OP_BRF  = 3'd3,
        OP_CALL = 3'd4,
        OP_RET  = 3'd5,
        OP_WAIT = 3'd6,
        OP_HALT = 3'd7
    } seq_op_e;

    typedef enum logic [1:0] {
        FSM_IDLE,
        FSM_RUN,
        FSM_HALTED,
        FSM_ERROR
    } fsm_e;

    // Packed MSB-first, so this matches [8:7] cond_sel, [6:4] op, [3:0] target.
    typedef struct packed {
        logic [1:0] cond_sel;
        seq_op_e    op;
        logic [3:0] target;
    } seq_field_t;

endpackage

// File: rtl/seq_stack.sv
// Return-address LIFO for the sequencer; level saturates at DEPTH and never
// goes below zero. Popped entries keep their contents.
module seq_stack
    import ctrl_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       push,
    input  logic       pop,
    input  logic [3:0] push_data,
    output logic [3:0] top_data,
    output logic       full,
    output logic       empty,
    output logic [2:0] level
);

    logic [3:0] stack_q [STACK_MAX];
    logic [3:0] stack_d [STACK_MAX];
    logic [2:0] level_q, level_d;
    logic [1:0] wr_idx, rd_idx;

    assign full     = (level_q == 3'(DEPTH));
    assign empty    = (level_q == 3'd0);
    assign level    = level_q;
    assign wr_idx   = level_q[1:0];
    assign rd_idx   = level_q[1:0] - 2'd1;
    assign top_data = stack_q[rd_idx];

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        stack_d = stack_q;
        level_d = level_q;
        if (clear) begin
            level_d = 3'd0;
        end else if (push && !full) begin
            stack_d[wr_idx] = push_data;
            level_d         = level_q + 3'd1;
        end else if (pop && !empty) begin
            level_d = level_q - 3'd1;
        end
    end

    // NOTE: the stack array is reset with the pointer so contents are known after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < STACK_MAX; i++) stack_q[i] <= 4'd0;
            level_q <= 3'd0;
        end else begin
            stack_q <= stack_d;
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/controller_sequencer.sv
// Microprogram sequencer: state register, op decode and control FSM.
// Optional single-step input enabled by defining SEQ_SINGLE_STEP_EN.
module controller_sequencer
    import ctrl_pkg::*;
#(
    parameter int         CW_WIDTH    = CW_WIDTH_DEF,
    parameter int         SEQ_LSB     = 0,
    parameter logic [3:0] RESET_ADDR  = RESET_ADDR_DEF,
    parameter int         STACK_DEPTH = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic                stall,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic                step,
`endif
    input  logic [CW_WIDTH-1:0] ctrl_word,
    input  logic [3:0]          cond_flags,
    output logic [3:0]          state,
    output logic                busy,
    output logic                halted,
    output logic                error,
    output logic [2:0]          stack_level
);

    fsm_e       fsm_q, fsm_d;
    logic [3:0] state_q, state_d;
    logic [3:0] state_inc;
    logic [3:0] top_data;
    logic       push, pop, clear, full, empty;
    logic       advance, cond;
    logic       unused_cw;
    seq_field_t seq;

    assign seq       = seq_field_t'(ctrl_word[SEQ_LSB +: SEQ_FIELD_W]);
    assign unused_cw = ^ctrl_word;
    assign cond      = cond_flags[seq.cond_sel];
    assign state_inc = state_q + 4'd1;

`ifdef SEQ_SINGLE_STEP_EN
    assign advance = !stall && step;
`else
    assign advance = !stall;
`endif

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        push    = 1'b0;
        pop     = 1'b0;
        clear   = 1'b0;
        if (abort) begin
            fsm_d   = FSM_IDLE;
            state_d = RESET_ADDR;
            clear   = 1'b1;
        end else begin
            unique case (fsm_q)
                FSM_IDLE: begin
                    state_d = RESET_ADDR;
                    if (start) fsm_d = FSM_RUN;
                end
                FSM_RUN: begin
                    if (advance) begin
                        unique case (seq.op)
                            OP_NEXT: state_d = state_inc;
                            OP_JUMP: state_d = seq.target;
                            OP_BRT:  state_d = cond ? seq.target : state_inc;
                            OP_BRF:  state_d = cond ? state_inc : seq.target;
                            OP_CALL: begin
                                if (full) begin
                                    fsm_d = FSM_ERROR;
                                end else begin
                                    push    = 1'b1;
                                    state_d = seq.target;
                                end
                            end
                            OP_RET: begin
                                if (empty) begin
                                    fsm_d = FSM_ERROR;
                                end else begin
                                    pop     = 1'b1;
                                    state_d = top_data;
                                end
                            end
                            OP_WAIT: if (cond) state_d = state_inc;
                            OP_HALT: fsm_d = FSM_HALTED;
                            default: state_d = state_q;
                        endcase
                    end
                end
                FSM_HALTED: begin
                    if (start) begin
                        fsm_d   = FSM_RUN;
                        state_d = state_inc;
                    end
                end
                FSM_ERROR: fsm_d = FSM_ERROR;
                default:   fsm_d = FSM_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments; combinational blocks use blocking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q   <= FSM_IDLE;
            state_q <= RESET_ADDR;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
        end
    end

    seq_stack #(
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .push      (push),
        .pop       (pop),
        .push_data (state_inc),
        .top_data  (top_data),
        .full      (full),
        .empty     (empty),
        .level     (stack_level)
    );

    assign state  = state_q;
    assign busy   = (fsm_q == FSM_RUN);
    assign halted = (fsm_q == FSM_HALTED);
    assign error  = (fsm_q == FSM_ERROR);

endmodule

// File: tb/tb_controller_sequencer.sv
// Scoreboard bench for controller_sequencer: stimulus pushes expected
// post-edge outputs, a negedge monitor pops and compares them.
module tb_controller_sequencer;
    import ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset, start, abort, stall;
    logic [39:0] ctrl_word;
    logic [3:0]  cond_flags;
    logic [3:0]  state;
    logic        busy, halted, error;
    logic [2:0]  stack_level;
`ifdef SEQ_SINGLE_STEP_EN
    logic        step = 1'b1;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string      name;
        logic [3:0] state;
        logic       busy;
        logic       halted;
        logic       error;
        logic [2:0] level;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    controller_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .stall       (stall),
`ifdef SEQ_SINGLE_STEP_EN
        .step        (step),
`endif
        .ctrl_word   (ctrl_word),
        .cond_flags  (cond_flags),
        .state       (state),
        .busy        (busy),
        .halted      (halted),
        .error       (error),
        .stack_level (stack_level)
    );

    function automatic logic [39:0] mk(input seq_op_e op, input logic [3:0] tgt,
                                       input logic [1:0] sel);
        return {31'h2A5C_3B17, sel, op, tgt};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // One clock of stimulus; expectation describes outputs after the next rising edge.
    task automatic cyc(input string name, input logic [39:0] cw, input logic [3:0] flags,
                       input logic st, input logic ab, input logic stl,
                       input logic [3:0] e_state, input logic e_busy, input logic e_halt,
                       input logic e_err, input logic [2:0] e_lvl);
        exp_t e;
        @(negedge clk);
        #1;
        ctrl_word  = cw;
        cond_flags = flags;
        start      = st;
        abort      = ab;
        stall      = stl;
        e.name   = name;
        e.state  = e_state;
        e.busy   = e_busy;
        e.halted = e_halt;
        e.error  = e_err;
        e.level  = e_lvl;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_checks++;
            if (state !== e.state || busy !== e.busy || halted !== e.halted ||
                error !== e.error || stack_level !== e.level) begin
                n_fail++;
                $display("FAIL %s: got state=%0d busy=%b halted=%b error=%b level=%0d expected state=%0d busy=%b halted=%b error=%b level=%0d",
                         e.name, state, busy, halted, error, stack_level,
                         e.state, e.busy, e.halted, e.error, e.level);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [39:0] junk;
        junk       = mk(OP_HALT, 4'd7, 2'd3);
        reset      = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        stall      = 1'b0;
        ctrl_word  = junk;
        cond_flags = 4'b0000;
        repeat (2) @(negedge clk);
        check("reset_state", 32'(state), 32'd0);
        check("reset_flags", 32'({busy, halted, error, stack_level}), 32'd0);
        #1 reset = 1'b0;

        // start from IDLE ignores ctrl_word, then NEXT up to state 5
        cyc("start0", junk, 4'h0, 1, 0, 0, 4'd0, 1, 0, 0, 3'd0);
        for (int i = 1; i <= 5; i++)
            cyc("next_run", mk(OP_NEXT, 4'd0, 2'd0), 4'h0, 0, 0, 0, 4'(i), 1, 0, 0, 3'd0);

        // asynchronous reset mid-cycle
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("async_reset_state", 32'(state), 32'd0);
        check("async_reset_busy", 32'({busy, stack_level}), 32'd0);
        #1 reset = 1'b0;

        cyc("restart",  junk, 4'h0, 1, 0, 0, 4'd0, 1, 0, 0, 3'd0);
        cyc("step1", mk(OP_NEXT, 4'd0, 2'd0), 4'h0, 0, 0, 0, 4'd1, 1, 0, 0, 3'd0);
        cyc("step2", mk(OP_NEXT, 4'd0, 2'd0), 4'h0, 0, 0, 0, 4'd2, 1, 0, 0, 3'd0);
        cyc("jump15", mk(OP_JUMP, 4'd15, 2'd0), 4'h0, 0, 0, 0, 4'd15, 1, 0, 0, 3'd0);
        cyc("wrap", mk(OP_NEXT, 4'd0, 2'd0), 4'h0, 0, 0, 0, 4'd0, 1, 0, 0, 3'd0);
        cyc("jump9", mk(OP_JUMP, 4'd9, 2'd0), 4'h0, 0, 0, 0, 4'd9, 1, 0, 0, 3'd0);

        cyc("brt_taken", mk(OP_BRT, 4'd3, 2'd2), 4'b0100, 0, 0, 0, 4'd3, 1, 0, 0, 3'd0);
        cyc("brt_not", mk(OP_BRT, 4'd3, 2'd2), 4'b0000, 0, 0, 0, 4'd4, 1, 0, 0, 3'd0);
        cyc("brf_taken", mk(OP_BRF, 4'd10, 2'd2), 4'b0000, 0, 0, 0, 4'd10, 1, 0, 0, 3'd0);
        cyc("brf_not", mk(OP_BRF, 4'd10, 2'd2), 4'b0100, 0, 0, 0, 4'd11, 1, 0, 0, 3'd0);

        cyc("jump2", mk(OP_JUMP, 4'd2, 2'd0), 4'h0, 0, 0, 0, 4'd2, 1, 0, 0, 3'd0);
        cyc("call8", mk(OP_CALL, 4'd8, 2'd0), 4'h0, 0, 0, 0, 4'd8, 1, 0, 0, 3'd1);
        cyc("call12", mk(OP_CALL, 4'd12, 2'd0), 4'h0, 0, 0, 0, 4'd12, 1, 0, 0, 3'd2);
        cyc("ret9", mk(OP_RET, 4'd0, 2'd0), 4'h0, 0, 0, 0, 4'd9, 1, 0, 0, 3'd1);
        cyc("ret3", mk(OP_RET, 4'd0, 2'd0), 4'h0, 0, 0, 0, 4'd3, 1, 0, 0, 3'd0);

        cyc("call8b", mk(OP_CALL, 4'd8, 2'd0), 4'h0, 0, 0, 0, 4'd8, 1, 0, 0, 3'd1);
        cyc("call12b", mk(OP_CALL, 4'd12, 2'd0), 4'h0, 0, 0, 0, 4'd12, 1, 0, 0, 3'd2);
        cyc("call_overflow", mk(OP_CALL, 4'd5, 2'd0), 4'h0, 0, 0, 0, 4'd12, 0, 0, 1, 3'd2);
        cyc("error_holds", mk(OP_JUMP, 4'd1, 2'd0), 4'h0, 1, 0, 0, 4'd12, 0, 0, 1, 3'd2);
        cyc("abort_error", mk(OP_JUMP, 4'd1, 2'd0), 4'h0, 0, 1, 0, 4'd0, 0, 0, 0, 3'd0);

        cyc("start_ret", junk, 4'h0, 1, 0, 0, 4'd0, 1, 0, 0, 3'd0);
        cyc("ret_underflow", mk(OP_RET, 4'd0, 2'd0), 4'h0, 0, 0, 0, 4'd0, 0, 0, 1, 3'd0);
        cyc("abort_error2", junk, 4'h0, 0, 1, 0, 4'd0, 0, 0, 0, 3'd0);

        cyc("start_wait", junk, 4'h0, 1, 0, 0, 4'd0, 1, 0, 0, 3'd0);
        cyc("jump4", mk(OP_JUMP, 4'd4, 2'd0), 4'h0, 0, 0, 0, 4'd4, 1, 0, 0, 3'd0);
        for (int i = 0; i < 4; i++)
            cyc("wait_hold", mk(OP_WAIT, 4'd0, 2'd1), 4'b1101, 0, 0, 0, 4'd4, 1, 0, 0, 3'd0);
        cyc("wait_go", mk(OP_WAIT, 4'd0, 2'd1), 4'b0010, 0, 0, 0, 4'd5, 1, 0, 0, 3'd0);

        cyc("stall_a", mk(OP_JUMP, 4'd13, 2'd0), 4'h0, 0, 0, 1, 4'd5, 1, 0, 0, 3'd0);
        cyc("stall_b", mk(OP_JUMP, 4'd13, 2'd0), 4'h0, 0, 0, 1, 4'd5, 1, 0, 0, 3'd0);
        cyc("stall_rel", mk(OP_JUMP, 4'd13, 2'd0), 4'h0, 0, 0, 0, 4'd13, 1, 0, 0, 3'd0);

        cyc("jump6", mk(OP_JUMP, 4'd6, 2'd0), 4'h0, 0, 0, 0, 4'd6, 1, 0, 0, 3'd0);
        cyc("halt6", mk(OP_HALT, 4'd0, 2'd0), 4'h0, 0, 0, 0, 4'd6, 0, 1, 0, 3'd0);
        cyc("halted_hold", mk(OP_JUMP, 4'd1, 2'd0), 4'h0, 0, 0, 0, 4'd6, 0, 1, 0, 3'd0);
        cyc("resume7", mk(OP_JUMP, 4'd1, 2'd0), 4'h0, 1, 0, 0, 4'd7, 1, 0, 0, 3'd0);
        cyc("halt7", mk(OP_HALT, 4'd0, 2'd0), 4'h0, 0, 0, 0, 4'd7, 0, 1, 0, 3'd0);
        cyc("abort_halted", mk(OP_HALT, 4'd0, 2'd0), 4'h0, 0, 1, 0, 4'd0, 0, 0, 0, 3'd0);
        cyc("idle_hold", mk(OP_JUMP, 4'd9, 2'd0), 4'h0, 0, 0, 0, 4'd0, 0, 0, 0, 3'd0);

        repeat (2) @(negedge clk);
        #2;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
